// File: rtl/spi_flash_reader.sv
// SPI config-flash reader: issues READ (0x03) + 24-bit address in SPI mode 0 and streams
// the returned bytes out on a valid/ready interface, freezing SCLK on backpressure.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             spi_clk,
  output logic             spi_cs,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned      DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0]  DivReload = DivW'(CLK_DIV - 1);
  localparam logic [7:0]       CmdRead   = 8'h03;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StCsSetup = 4'd1;
  localparam logic [3:0] StCmd     = 4'd2;
  localparam logic [3:0] StAddr    = 4'd3;
  localparam logic [3:0] StData    = 4'd4;
  localparam logic [3:0] StStall   = 4'd5;
  localparam logic [3:0] StCsHold  = 4'd6;
  localparam logic [3:0] StCsGap   = 4'd7;
  localparam logic [3:0] StDone    = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic [30:0]      tx_q, tx_d;     // bits still to send after the current MOSI bit
  logic [4:0]       bit_q, bit_d;
  logic [7:0]       rx_q, rx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d; // rx_q holds a completed byte not yet in data_q
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;

  logic       div_zero;
  logic       can_load;
  logic [7:0] rx_next;

  assign div_zero = (div_q == '0);
  // Output register is free if empty or being drained this cycle.
  assign can_load = !valid_q || data_ready;
  assign rx_next  = {rx_q[6:0], spi_miso};

  // Next-state logic for the transaction sequencer and SCLK generator.
  always_comb begin
    state_d = state_q;
    div_d   = div_zero ? DivReload : div_q - DivW'(1);
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (valid_q && data_ready) valid_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (len != '0) begin
            state_d = StCsSetup;
            cs_d    = 1'b0;
            mosi_d  = CmdRead[7];
            tx_d    = {CmdRead[6:0], addr};
            rem_d   = len;
            bit_d   = '0;
            div_d   = DivReload;
          end else begin
            state_d = StDone;
          end
        end
      end

      StCsSetup: begin
        if (div_zero) begin
          sclk_d  = 1'b1;
          state_d = StCmd;
        end
      end

      StCmd, StAddr: begin
        if (div_zero) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: present the next bit while SCLK is low.
            sclk_d = 1'b0;
            mosi_d = tx_q[30];
            tx_d   = {tx_q[29:0], 1'b0};
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd7) state_d = StAddr;
            if (bit_q == 5'd31) begin
              state_d = StData;
              mosi_d  = 1'b0;
              bit_d   = '0;
            end
          end
        end
      end

      StData: begin
        if (pend_q && can_load) begin
          data_d  = rx_q;
          valid_d = 1'b1;
          pend_d  = 1'b0;
        end
        if (div_zero) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = rx_next;
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd7) begin
              bit_d = '0;
              rem_d = rem_q - LEN_W'(1);
              if (can_load) begin
                data_d  = rx_next;
                valid_d = 1'b1;
              end else begin
                pend_d = 1'b1;
              end
            end
          end else begin
            sclk_d = 1'b0;
            if (pend_d)             state_d = StStall;
            else if (rem_q == '0)   state_d = StCsHold;
          end
        end
      end

      StStall: begin
        if (can_load) begin
          data_d  = rx_q;
          valid_d = 1'b1;
          pend_d  = 1'b0;
          div_d   = DivReload;
          state_d = (rem_q == '0) ? StCsHold : StData;
        end
      end

      StCsHold: begin
        if (div_zero) begin
          cs_d    = 1'b1;
          bit_d   = '0;
          state_d = StCsGap;
        end
      end

      // CS-high time spans two half-periods before done.
      StCsGap: begin
        if (div_zero) begin
          if (!bit_q[0]) bit_d = 5'd1;
          else           state_d = StDone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      rem_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Status and pin outputs decoded from registered state.
  always_comb begin
    busy       = (state_q != StIdle) && (state_q != StDone);
    done       = (state_q == StDone);
    data       = data_q;
    data_valid = valid_q;
    spi_clk    = sclk_q;
    spi_cs     = cs_q;
    spi_mosi   = mosi_q;
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three instances (CLK_DIV 2, 1, 5) share stimulus; each has its
// own flash model and monitor that pops expected bytes/transactions from scoreboard queues.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        data_ready = 1'b1;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic [2:0]  busy, done, data_valid, spi_clk, spi_cs, spi_mosi;
  logic [7:0]  data [3];

  int vectors = 0;
  int errors = 0;

  logic [7:0]  exp_byte [3][$];
  logic [47:0] exp_txn  [3][$];  // {sclk rises, first 32 MOSI bits}

  always #5 clk = ~clk;

  task automatic check(input string name, input int g, input logic [47:0] act,
                       input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h100000: flash_byte = 8'hDE;
      24'h100001: flash_byte = 8'hAD;
      24'h100002: flash_byte = 8'hBE;
      24'h100003: flash_byte = 8'hEF;
      default:    flash_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int Div = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic        miso;
    logic [7:0]  fb;
    logic [7:0]  e;
    logic [47:0] t;
    int          rises = 0;
    int          done_cnt = 0;
    int          hi_cnt = 0;
    int          lo_cnt = 0;
    int          gap_cnt = 0;
    logic        gap_valid = 1'b0;
    logic        stall_seen = 1'b0;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;
    logic [31:0] acc = '0;

    spi_flash_reader #(.CLK_DIV(Div), .LEN_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .addr       (addr),
      .len        (len),
      .busy       (busy[g]),
      .done       (done[g]),
      .data       (data[g]),
      .data_valid (data_valid[g]),
      .data_ready (data_ready),
      .spi_clk    (spi_clk[g]),
      .spi_cs     (spi_cs[g]),
      .spi_mosi   (spi_mosi[g]),
      .spi_miso   (miso)
    );

    // Flash model: after 32 command/address rises, drive data bits MSB first.
    always_comb begin
      fb   = '0;
      miso = 1'b0;
      if (rises >= 32) begin
        fb   = flash_byte(acc[23:0] + 24'((rises - 32) / 8));
        miso = fb[3'(7 - ((rises - 32) % 8))];
      end
    end

    // Monitor: SCLK phase timing, CS gap, byte scoreboard, transaction summary at done.
    always @(negedge clk) begin
      if (reset) begin
        rises = 0; acc = '0; hi_cnt = 0; lo_cnt = 0;
        gap_valid = 1'b0; stall_seen = 1'b0; sclk_prev = 1'b0; cs_prev = 1'b1;
      end else begin
        if (!spi_cs[g] && cs_prev) begin
          if (gap_valid) check("cs_gap_min", g, 48'(gap_cnt >= 2 * Div), 48'd1);
          rises = 0; acc = '0; lo_cnt = 0; stall_seen = 1'b0;
        end
        if (spi_cs[g] && !cs_prev) begin
          gap_cnt = 0; gap_valid = 1'b1;
        end
        if (spi_cs[g]) gap_cnt++;
        if (spi_clk[g] && !sclk_prev) begin
          if (!stall_seen) check("sclk_low_len", g, 48'(lo_cnt), 48'(Div));
          hi_cnt = 0;
          if (rises < 32) acc = {acc[30:0], spi_mosi[g]};
          rises++;
        end
        if (!spi_clk[g] && sclk_prev) begin
          check("sclk_high_len", g, 48'(hi_cnt), 48'(Div));
          lo_cnt = 0; stall_seen = 1'b0;
        end
        if (spi_clk[g]) hi_cnt++;
        else lo_cnt++;
        if (!data_ready) stall_seen = 1'b1;

        if (data_valid[g] && data_ready) begin
          if (exp_byte[g].size() == 0) begin
            check("unexpected_byte", g, 48'(data[g]), 48'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_byte[g].pop_front();
            check("data_byte", g, 48'(data[g]), 48'(e));
          end
        end
        if (done[g]) begin
          check("busy_at_done", g, 48'(busy[g]), 48'd0);
          if (exp_txn[g].size() == 0) begin
            check("unexpected_done", g, 48'(done[g]), 48'd0);
          end else begin
            t = exp_txn[g].pop_front();
            check("txn_rises", g, 48'(rises), 48'(t[47:32]));
            check("txn_mosi", g, 48'(acc), 48'(t[31:0]));
          end
          rises = 0; acc = '0;
          done_cnt++;
        end
        sclk_prev = spi_clk[g];
        cs_prev   = spi_cs[g];
      end
    end
  end

  function automatic logic all_done(input int target);
    all_done = (inst[0].done_cnt >= target) && (inst[1].done_cnt >= target) &&
               (inst[2].done_cnt >= target);
  endfunction

  task automatic expect_byte(input logic [7:0] b);
    for (int g = 0; g < 3; g++) exp_byte[g].push_back(b);
  endtask

  task automatic expect_txn(input int r, input logic [31:0] w);
    for (int g = 0; g < 3; g++) exp_txn[g].push_back({16'(r), w});
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
    @(negedge clk);
    addr = a; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int t = 0;
    while (!all_done(target) && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", 0, 48'(all_done(target)), 48'd1);
  endtask

  initial begin
    int t;
    int r0, r1, r2;

    // Reset state.
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_cs", g, 48'(spi_cs[g]), 48'd1);
      check("rst_sclk", g, 48'(spi_clk[g]), 48'd0);
      check("rst_mosi", g, 48'(spi_mosi[g]), 48'd0);
      check("rst_busy", g, 48'(busy[g]), 48'd0);
      check("rst_done", g, 48'(done[g]), 48'd0);
      check("rst_valid", g, 48'(data_valid[g]), 48'd0);
      check("rst_data", g, 48'(data[g]), 48'd0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 4-byte read with free-flowing downstream.
    expect_byte(8'hDE); expect_byte(8'hAD); expect_byte(8'hBE); expect_byte(8'hEF);
    expect_txn(64, 32'h0310_0000);
    pulse_start(24'h100000, 16'd4);
    wait_done(1, 3000);
    repeat (10) @(negedge clk);

    // Backpressure: second byte parks in the shift register and SCLK freezes.
    data_ready = 1'b0;
    expect_byte(8'hDE); expect_byte(8'hAD); expect_byte(8'hBE); expect_byte(8'hEF);
    expect_txn(64, 32'h0310_0000);
    pulse_start(24'h100000, 16'd4);
    t = 0;
    while (!(&data_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("first_byte_seen", 0, 48'(&data_valid), 48'd1);
    repeat (100) @(negedge clk);
    r0 = inst[0].rises; r1 = inst[1].rises; r2 = inst[2].rises;
    repeat (100) @(negedge clk);
    check("stall_frozen", 0, 48'(inst[0].rises), 48'(r0));
    check("stall_frozen", 1, 48'(inst[1].rises), 48'(r1));
    check("stall_frozen", 2, 48'(inst[2].rises), 48'(r2));
    for (int g = 0; g < 3; g++) begin
      check("stall_sclk_low", g, 48'(spi_clk[g]), 48'd0);
      check("stall_cs_low", g, 48'(spi_cs[g]), 48'd0);
      check("stall_valid", g, 48'(data_valid[g]), 48'd1);
      check("stall_data", g, 48'(data[g]), 48'hDE);
    end
    data_ready = 1'b1;
    wait_done(2, 3000);
    repeat (10) @(negedge clk);

    // Zero-length request: done next cycle, no CS activity.
    expect_txn(0, 32'h0);
    @(negedge clk);
    addr = 24'h123456; len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", 0, 48'(done), 48'h7);
    check("len0_busy", 0, 48'(busy), 48'h0);
    check("len0_cs", 0, 48'(spi_cs), 48'h7);
    @(negedge clk);
    check("len0_done_pulse", 0, 48'(done), 48'h0);
    for (int i = 0; i < 8; i++) begin
      check("len0_cs_idle", 0, 48'(spi_cs & ~busy), 48'h7);
      @(negedge clk);
    end
    wait_done(3, 10);

    // Reset in the middle of the address phase, then a fresh read.
    data_ready = 1'b0;
    pulse_start(24'h00A5C3, 16'd3);
    t = 0;
    while (inst[0].rises < 16 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("reached_addr", 0, 48'(inst[0].rises >= 16), 48'd1);
    reset = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("abort_cs", g, 48'(spi_cs[g]), 48'd1);
      check("abort_sclk", g, 48'(spi_clk[g]), 48'd0);
      check("abort_busy", g, 48'(busy[g]), 48'd0);
      check("abort_done", g, 48'(done[g]), 48'd0);
      check("abort_valid", g, 48'(data_valid[g]), 48'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    data_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 0, 48'(done), 48'h0);
    expect_byte(8'h4A); expect_byte(8'h4B); expect_byte(8'h48);
    expect_txn(56, 32'h0300_0010);
    pulse_start(24'h000010, 16'd3);
    wait_done(4, 3000);
    repeat (10) @(negedge clk);

    // Spurious start pulses while busy must be ignored.
    expect_byte(8'hAA); expect_byte(8'hAB);
    expect_txn(48, 32'h0300_00F0);
    pulse_start(24'h0000F0, 16'd2);
    t = 0;
    while (!all_done(5) && t < 3000) begin
      @(negedge clk);
      t++;
      if (start) begin
        start = 1'b0;
      end else if ((&busy) && $urandom_range(0, 5) == 0) begin
        addr  = 24'hFFFFFF ^ 24'(t);
        len   = 16'd7;
        start = 1'b1;
      end
    end
    start = 1'b0;
    check("done_reached", 0, 48'(all_done(5)), 48'd1);
    repeat (20) @(negedge clk);

    for (int g = 0; g < 3; g++) begin
      check("bytes_outstanding", g, 48'(exp_byte[g].size()), 48'd0);
      check("txns_outstanding", g, 48'(exp_txn[g].size()), 48'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
